// File: rtl/rfa_fu_wb_queue.sv
// Write-back request FIFO between one SIMD/SIMF functional unit and the register file arbiter.
// Presents the head request to the arbiter and tracks how long that head has been waiting.
module rfa_fu_wb_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PTR_W     = 2,
   parameter int unsigned PAYLOAD_W = 64,
   parameter int unsigned AGE_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fu_req_valid,
   input  logic [PAYLOAD_W-1:0] fu_req_payload,
   output logic                 fu_req_ready,
   output logic                 queue_entry_valid,
   input  logic                 queue_entry_serviced,
   output logic [PAYLOAD_W-1:0] head_payload,
   output logic [PTR_W:0]       entry_count,
   output logic [AGE_W-1:0]     head_age,
   output logic [1:0]           err_sticky
);

   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count, count_next;
   logic                 push, pop, not_empty;
   logic [AGE_W-1:0]     age_next;
   logic [1:0]           err_next;

   assign not_empty         = (count != '0);
   assign queue_entry_valid = not_empty;
   assign entry_count       = count;
   assign head_payload      = not_empty ? mem[rd_ptr] : '0;

   // A pop in the same cycle frees a slot, so a full queue can still accept.
   assign fu_req_ready = (count < CNT_W'(DEPTH)) | queue_entry_serviced;

   always_comb begin
      push       = fu_req_valid & fu_req_ready;
      pop        = queue_entry_serviced & not_empty;
      count_next = count;
      age_next   = head_age;
      err_next   = err_sticky;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);
      // Age restarts whenever a new head is presented or the queue is empty.
      if (pop || count_next == '0)
         age_next = '0;
      else if (not_empty && head_age != AGE_MAX)
         age_next = head_age + AGE_W'(1);
      if (fu_req_valid && !fu_req_ready)
         err_next[0] = 1'b1;
      if (queue_entry_serviced && !not_empty)
         err_next[1] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_age   <= '0;
         err_sticky <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count      <= count_next;
         head_age   <= age_next;
         err_sticky <= err_next;
      end
   end

   // Storage carries no reset; empty slots are masked on the head output.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= fu_req_payload;
   end

endmodule

// File: tb/tb_rfa_fu_wb_queue.sv
// Directed self-checking bench for rfa_fu_wb_queue (DEPTH=4, PAYLOAD_W=64, AGE_W=8).
module tb_rfa_fu_wb_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        fu_req_valid;
   logic [63:0] fu_req_payload;
   logic        fu_req_ready;
   logic        queue_entry_valid;
   logic        queue_entry_serviced;
   logic [63:0] head_payload;
   logic [2:0]  entry_count;
   logic [7:0]  head_age;
   logic [1:0]  err_sticky;

   int errors   = 0;
   int n_checks = 0;

   rfa_fu_wb_queue dut (
      .clk                  (clk),
      .rst                  (rst),
      .fu_req_valid         (fu_req_valid),
      .fu_req_payload       (fu_req_payload),
      .fu_req_ready         (fu_req_ready),
      .queue_entry_valid    (queue_entry_valid),
      .queue_entry_serviced (queue_entry_serviced),
      .head_payload         (head_payload),
      .entry_count          (entry_count),
      .head_age             (head_age),
      .err_sticky           (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [63:0] p);
      fu_req_valid   = 1'b1;
      fu_req_payload = p;
      step();
      fu_req_valid   = 1'b0;
   endtask

   task automatic fill_11_44();
      for (int i = 0; i < 4; i++) begin
         push_one(64'(8'h11 * (i + 1)));
         chk("fill_count", 64'(entry_count), 64'(i + 1));
      end
      chk("full_ready", 64'(fu_req_ready), 64'd0);
   endtask

   task automatic drain_expect(input logic [63:0] first);
      queue_entry_serviced = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", head_payload, first + 64'(8'h11 * i));
         step();
      end
      queue_entry_serviced = 1'b0;
      chk("drain_valid", 64'(queue_entry_valid), 64'd0);
      chk("drain_count", 64'(entry_count), 64'd0);
   endtask

   initial begin
      rst                  = 1'b0;
      fu_req_valid         = 1'b0;
      fu_req_payload       = '0;
      queue_entry_serviced = 1'b0;
      step();
      step();
      chk("rst_valid", 64'(queue_entry_valid), 64'd0);
      chk("rst_ready", 64'(fu_req_ready), 64'd1);
      chk("rst_count", 64'(entry_count), 64'd0);
      chk("rst_head", head_payload, 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_valid", 64'(queue_entry_valid), 64'd0);
         chk("idle_ready", 64'(fu_req_ready), 64'd1);
         chk("idle_count", 64'(entry_count), 64'd0);
         chk("idle_age", 64'(head_age), 64'd0);
         chk("idle_err", 64'(err_sticky), 64'd0);
      end

      // Fill and drain
      fill_11_44();
      chk("full_head", head_payload, 64'h11);
      drain_expect(64'h11);

      // Full with simultaneous push and pop, then wrap-around drain
      fill_11_44();
      fu_req_valid         = 1'b1;
      fu_req_payload       = 64'h55;
      queue_entry_serviced = 1'b1;
      #1;
      chk("full_pop_ready", 64'(fu_req_ready), 64'd1);
      step();
      fu_req_valid         = 1'b0;
      queue_entry_serviced = 1'b0;
      chk("pp_count", 64'(entry_count), 64'd4);
      chk("pp_head", head_payload, 64'h22);
      drain_expect(64'h22);
      chk("no_err", 64'(err_sticky), 64'd0);

      // Push while full is dropped
      fill_11_44();
      push_one(64'h66);
      chk("ovf_err", 64'(err_sticky), 64'd1);
      chk("ovf_count", 64'(entry_count), 64'd4);
      drain_expect(64'h11);

      // Service while empty
      queue_entry_serviced = 1'b1;
      step();
      queue_entry_serviced = 1'b0;
      chk("udf_err", 64'(err_sticky), 64'd3);
      chk("udf_count", 64'(entry_count), 64'd0);
      chk("udf_valid", 64'(queue_entry_valid), 64'd0);
      step();
      chk("err_hold", 64'(err_sticky), 64'd3);

      // Head aging with saturation
      push_one(64'hA5);
      chk("age_0", 64'(head_age), 64'd0);
      chk("age_head", head_payload, 64'hA5);
      for (int k = 1; k < 300; k++) begin
         step();
         chk("age_k", 64'(head_age), 64'((k > 255) ? 255 : k));
      end
      queue_entry_serviced = 1'b1;
      step();
      queue_entry_serviced = 1'b0;
      chk("age_clr", 64'(head_age), 64'd0);
      chk("age_empty", 64'(entry_count), 64'd0);

      // Asynchronous reset between clock edges
      push_one(64'h01);
      push_one(64'h02);
      push_one(64'h03);
      chk("pre_rst_count", 64'(entry_count), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 64'(queue_entry_valid), 64'd0);
      chk("arst_count", 64'(entry_count), 64'd0);
      chk("arst_ready", 64'(fu_req_ready), 64'd1);
      chk("arst_err", 64'(err_sticky), 64'd0);
      chk("arst_head", head_payload, 64'd0);
      step();
      rst = 1'b1;
      push_one(64'h77);
      chk("post_head", head_payload, 64'h77);
      chk("post_count", 64'(entry_count), 64'd1);
      chk("post_age", 64'(head_age), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rfa_fu_wb_queue.md
Name: rfa_fu_wb_queue

Overview:
- Per-functional-unit write-back request queue directly upstream of the register file arbiter (rfa).
- One instance per SIMD/SIMF unit; the eight instances drive simd0..3/simf0..3_queue_entry_valid into the arbiter and consume the matching queue_entry_serviced.
- Buffers FU result write-back requests until the arbiter grants the VGPR/SGPR write port, and exposes the head request payload for the arbiter-selected mux.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).
- PAYLOAD_W, 64, width of one write-back request (dest addr, wfid, exec mask slice, tag; opaque to this block).
- AGE_W, 8, width of the head-wait saturating counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- fu_req_valid  input  1  FU presents a write-back request this cycle.
- fu_req_payload  input  PAYLOAD_W  request payload, sampled when accepted.
- fu_req_ready  output  1  queue can accept this cycle.
- queue_entry_valid  output  1  head entry present; goes to the rfa.
- queue_entry_serviced  input  1  rfa grant for this queue; pops the head.
- head_payload  output  PAYLOAD_W  payload of the head entry.
- entry_count  output  PTR_W+1  number of occupied entries.
- head_age  output  AGE_W  cycles the current head has waited, saturating.
- err_sticky  output  2  bit0 = push while not ready; bit1 = serviced while empty.

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, head_age=0, err_sticky=0. queue_entry_valid=0, fu_req_ready=1, entry_count=0, head_payload=0. Storage contents need not be reset. Reset mid-operation discards all entries immediately. Outputs hold their reset values until the first clk edge after rst returns to 1.
- push = fu_req_valid & fu_req_ready; pop = queue_entry_serviced & queue_entry_valid.
- fu_req_ready = (count < DEPTH) | queue_entry_serviced. When the queue is full, a same-cycle pop frees the slot and the push is accepted. This is a combinational path from serviced to ready, which is permitted.
- Push: payload is written at wr_ptr, then wr_ptr increments modulo DEPTH and wraps naturally.
- Pop: rd_ptr increments modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged when both occur or neither occurs.
- Latency: a request accepted at edge N is visible as queue_entry_valid=1 and head_payload after edge N. There is no combinational bypass from fu_req_* to the outputs.
- queue_entry_valid = (count != 0). head_payload is the storage entry at rd_ptr and is 0 when empty.
- The rfa may drive serviced combinationally from valid in the same cycle. The queue pops at the edge that samples serviced=1 with valid=1, and the next entry is presented immediately after that edge.
- Push and pop when count=1: the old head leaves, the new entry becomes the head, and count stays 1.
- Push and pop when count=0: only the push occurs (pop requires valid), and count becomes 1.
- head_age:
  - cleared to 0 on a pop, and on any edge where the queue becomes or remains empty;
  - otherwise increments by 1 per cycle while valid is 1, saturating at 2^AGE_W−1.
  - A head that arrives at edge N shows age 0 after N, then age 1 after N+1, and so on.
- err_sticky:
  - bit0 is set when fu_req_valid=1 and fu_req_ready=0; the request is dropped and no state changes.
  - bit1 is set when queue_entry_serviced=1 and count=0; it is ignored.
  - Both bits clear only on reset.
- Order is strict FIFO. The block never reorders or duplicates entries.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release with no stimulus -> valid=0, ready=1, entry_count=0, head_age=0, err_sticky=00 throughout.
- Fill and drain: push payloads 0x11, 0x22, 0x33, 0x44 on consecutive cycles with serviced=0 -> entry_count reaches 4 and ready=0.
  - Then assert serviced for 4 cycles -> head_payload sequence is 0x11, 0x22, 0x33, 0x44, then valid=0 and entry_count=0.
- Full with simultaneous push/pop: with the queue full of 0x11..0x44, assert push 0x55 together with serviced -> push accepted, entry_count stays 4, head becomes 0x22. Draining then yields 0x22, 0x33, 0x44, 0x55, proving wrap-around.
- Error flags:
  - Push 0x66 while full and serviced=0 -> err_sticky=01 and 0x66 never appears.
  - Then empty the queue and pulse serviced -> err_sticky=11, which persists until rst=0.
- Head aging: push one entry and hold serviced=0 for 300 cycles -> head_age counts 0, 1, 2, … and saturates at 255 (AGE_W=8). A pop then clears head_age to 0.
- Async reset mid-operation: with 3 entries queued, drive rst=0 between clock edges -> valid=0, entry_count=0, ready=1 immediately, without waiting for a clock. After release, the first new push 0x77 is the head.
